// File: rtl/proc_pkg.sv
// proc_pkg: opcode, imm_code and instruction-field definitions shared by encoder and decoder
package proc_pkg;
    localparam int INSTR_W   = 12;
    localparam int OPC_LSB   = 9;
    localparam int FUNCT_BIT = 8;
    localparam int REGS_LSB  = 2;
    localparam int CODE_LSB  = 0;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_LDST = 3'd4;
    localparam logic [2:0] OP_JMP  = 3'd6;
    localparam logic [2:0] OP_MOV  = 3'd7;
    localparam logic [1:0] IMM_C0 = 2'd0;
    localparam logic [1:0] IMM_C1 = 2'd1;
    localparam logic [1:0] IMM_C2 = 2'd2;
    localparam logic [1:0] IMM_C3 = 2'd3;
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               err;
    } entry_t;
endpackage

// File: rtl/instr_imm_encoder_if.sv
// instr_imm_encoder_if: request and instruction-word handshakes of the immediate encoder
interface instr_imm_encoder_if;
    import proc_pkg::*;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [2:0]         opcode_i;
    logic               funct_i;
    logic [5:0]         regs_i;
    logic [15:0]        imm_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [INSTR_W-1:0] out_instr_o;
    logic               out_err_o;
    modport slave (
        input  in_valid_i, opcode_i, funct_i, regs_i, imm_i, out_ready_i,
        output in_ready_o, out_valid_o, out_instr_o, out_err_o
    );
    modport master (
        output in_valid_i, opcode_i, funct_i, regs_i, imm_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_instr_o, out_err_o
    );
endinterface

// File: rtl/imm_encode_lut.sv
// imm_encode_lut: maps {opcode, funct, imm} to the canonical imm_code, flagging values the decoder cannot produce
module imm_encode_lut
    import proc_pkg::*;
(
    input  logic [2:0]         opcode,
    input  logic               funct,
    input  logic signed [15:0] imm,
    output logic [1:0]         code,
    output logic               bad
);
    // Inverse of the decode table; unencodable values always fall back to code 0
    always_comb begin
        code = IMM_C0;
        bad  = 1'b0;
        case (opcode)
            OP_ADDI: begin
                code = (!funct && imm == 16'sd30) ? IMM_C1 : IMM_C0;
                bad  = funct ? imm != -16'sd1 : (imm != 16'sd31 && imm != 16'sd30);
            end
            OP_LDST: begin
                code = imm == 16'sd2 ? IMM_C2 : imm == 16'sd4 ? IMM_C3 : IMM_C0;
                bad  = imm != 16'sd0 && imm != 16'sd2 && imm != 16'sd4;
            end
            OP_JMP: bad = imm != (funct ? 16'sd1 : -16'sd1);
            OP_MOV: begin
                code = funct ? IMM_C0 : imm == 16'sd1 ? IMM_C1 : imm == 16'sd127 ? IMM_C2 : IMM_C0;
                bad  = funct ? imm != 16'sd1 : (imm != 16'sd0 && imm != 16'sd1 && imm != 16'sd127);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/instr_imm_encoder.sv
// instr_imm_encoder: packs requests into 12-bit instruction words via a 2-entry buffer and counts unencodable immediates
module instr_imm_encoder
    import proc_pkg::*;
#(
    parameter bit DROP_ON_ERR = 1'b0,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_imm_encoder_if.slave   bus,
    input  logic                 flush_i,
    input  logic                 clear_err_i,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 err_sticky_o
);
    logic [1:0]           code;
    logic                 bad;
    logic                 accept, push, pop, err_fire;
    logic [INSTR_W-1:0]   instr;
    entry_t               mem_q [2];
    entry_t               mem_d [2];
    logic                 wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]           count_q, count_d;
    logic                 in_ready_q, in_ready_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_sticky_q, err_sticky_d;

    imm_encode_lut u_lut (
        .opcode (bus.opcode_i),
        .funct  (bus.funct_i),
        .imm    (bus.imm_i),
        .code   (code),
        .bad    (bad)
    );

    // Next-state of buffer and error counter; flush discards the cycle's push and pop but not its error
    always_comb begin
        instr = '0;
        instr[OPC_LSB +: 3]  = bus.opcode_i;
        instr[FUNCT_BIT]     = bus.funct_i;
        instr[REGS_LSB +: 6] = bus.regs_i;
        instr[CODE_LSB +: 2] = code;
        accept   = bus.in_valid_i & in_ready_q;
        err_fire = accept & bad;
        push     = accept & ~flush_i & ~(DROP_ON_ERR & bad);
        pop      = (count_q != 2'd0) & bus.out_ready_i & ~flush_i;
        mem_d    = mem_q;
        if (push) mem_d[wptr_q] = '{instr: instr, err: bad};
        wptr_d     = flush_i ? 1'b0 : wptr_q ^ push;
        rptr_d     = flush_i ? 1'b0 : rptr_q ^ pop;
        count_d    = flush_i ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        in_ready_d = count_d != 2'd2;
        err_cnt_d  = clear_err_i ? '0 : err_cnt_q + ERR_CNT_W'(err_fire & ~&err_cnt_q);
        err_sticky_d = ~clear_err_i & (err_sticky_q | err_fire);
    end

    // State registers, cleared asynchronously so reset empties the buffer at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q        <= '{default: '0};
            wptr_q       <= 1'b0;
            rptr_q       <= 1'b0;
            count_q      <= 2'd0;
            in_ready_q   <= 1'b1;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = count_q != 2'd0;
    assign bus.out_instr_o = bus.out_valid_o ? mem_q[rptr_q].instr : '0;
    assign bus.out_err_o   = bus.out_valid_o & mem_q[rptr_q].err;
    assign err_cnt_o       = err_cnt_q;
    assign err_sticky_o    = err_sticky_q;
endmodule
